// File: rtl/mask_gen_pkg.sv
// Shared constants and helpers for the rotating one-hot mask generator.
// No ports. The helpers work on a fixed-width vector (MASK_GEN_NB_MAX bits).
// Callers zero-extend into that vector and pass the live width nb, so one
// function body serves every legal NB.
package mask_gen_pkg;

    localparam int unsigned MASK_GEN_NB_DEFAULT = 8;
    localparam int unsigned MASK_GEN_NB_MAX     = 256;
    localparam int unsigned MASK_GEN_IDX_W      = $clog2(MASK_GEN_NB_MAX);

    typedef logic [MASK_GEN_NB_MAX-1:0] mask_vec_t;

    // Rotate the low nb bits left by one. Bits at or above nb are returned as zero.
    function automatic mask_vec_t rotl1(input mask_vec_t vec, input int unsigned nb);
        mask_vec_t ones;
        mask_vec_t keep;
        mask_vec_t res;
        ones   = '1;
        keep   = ~(ones << nb);
        res    = (vec << 1) & keep;
        res[0] = vec[MASK_GEN_IDX_W'(nb - 1)];
        return res;
    endfunction

    // Exactly one bit set. The caller supplies a zero-extended vector.
    function automatic logic is_onehot(input mask_vec_t vec);
        return $onehot(vec);
    endfunction

endpackage

// File: rtl/mask_gen_ring.sv
// NB-bit one-hot ring register with enable and self-correction.
// Ports:
//   clk          - rising-edge clock
//   n_rst        - asynchronous active-low reset; loads bit 0 only
//   shift_enable - rotate left by one on this clock edge
//   mask         - ring register contents, driven straight from the flops
module mask_gen_ring
    import mask_gen_pkg::*;
#(
    parameter int NB = int'(MASK_GEN_NB_DEFAULT)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          shift_enable,
    output logic [NB-1:0] mask
);

    if (NB < 1 || NB > int'(MASK_GEN_NB_MAX)) begin : g_nb_check
        $fatal(1, "mask_gen_ring: NB=%0d outside 1..%0d", NB, MASK_GEN_NB_MAX);
    end

    localparam logic [NB-1:0] MASK_RST = NB'(1);

    logic [NB-1:0] mask_q;
    logic [NB-1:0] mask_d;
    mask_vec_t     mask_wide;

    assign mask_wide = MASK_GEN_NB_MAX'(mask_q);

    // Next state: recover from any non-one-hot value first, then rotate or hold.
    always_comb begin
        mask_d = mask_q;
        if (!is_onehot(mask_wide)) begin
            mask_d = MASK_RST;
        end else if (shift_enable) begin
            mask_d = NB'(rotl1(mask_wide, 32'(NB)));
        end
    end

    // Ring register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mask_q <= MASK_RST;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: rtl/mask_gen.sv
// Rotating one-hot mask generator, top level.
// Ports:
//   clk          - rising-edge clock
//   n_rst        - asynchronous active-low reset; mask returns to bit 0
//   shift_enable - advance the mask one position per clock
//   mask         - NB-bit one-hot mask, registered (no path from shift_enable)
// Define MASK_GEN_ASSERT_EN to compile in the runtime protocol assertions.
module mask_gen
    import mask_gen_pkg::*;
#(
    parameter int NB = int'(MASK_GEN_NB_DEFAULT)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          shift_enable,
    output logic [NB-1:0] mask
);

    if (NB < 1) begin : g_nb_check
        $fatal(1, "mask_gen: NB=%0d must be at least 1", NB);
    end

    mask_gen_ring #(
        .NB (NB)
    ) u_ring (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .mask         (mask)
    );

`ifdef MASK_GEN_ASSERT_EN
    logic [NB-1:0] mask_rotl_c;

    assign mask_rotl_c = NB'(rotl1(MASK_GEN_NB_MAX'(mask), 32'(NB)));

    a_onehot : assert property (@(posedge clk) disable iff (!n_rst) $onehot(mask))
        else $error("mask_gen: mask not one-hot, mask=%0h prev=%0h", mask, $past(mask));

    a_hold : assert property (@(posedge clk) disable iff (!n_rst)
                              !shift_enable |=> (mask == $past(mask)))
        else $error("mask_gen: hold violated, mask=%0h prev=%0h", mask, $past(mask));

    a_rotate : assert property (@(posedge clk) disable iff (!n_rst)
                                shift_enable |=> (mask == $past(mask_rotl_c)))
        else $error("mask_gen: rotate violated, mask=%0h prev=%0h", mask, $past(mask));
`endif

endmodule

// File: tb/tb_mask_gen.sv
// Directed self-checking bench for mask_gen with NB=8.
module tb_mask_gen;

    localparam int NB = 8;

    logic          clk;
    logic          n_rst;
    logic          shift_enable;
    logic [NB-1:0] mask;

    int unsigned n_checks;
    int unsigned n_fail;

    mask_gen #(
        .NB (NB)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .mask         (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] exp);
        n_checks++;
        assert (mask === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, mask, exp);
        end
    endtask

    // Step one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [NB-1:0] exp_seq [8];
        n_checks     = 0;
        n_fail       = 0;
        exp_seq      = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        // Asynchronous reset with no clock edge yet.
        n_rst        = 1'b1;
        shift_enable = 1'b1;
        #1 n_rst     = 1'b0;
        #1;
        check("reset_async", 8'h01);

        // A clock edge under reset keeps bit 0 despite shift_enable.
        tick();
        check("reset_held_clk", 8'h01);

        // Release at falling edge, then rotate through a full period.
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rotate_%0d", i), exp_seq[i]);
        end

        // Four more edges, 12 in total.
        tick(); check("rotate_9", 8'h02);
        tick(); check("rotate_10", 8'h04);
        tick(); check("rotate_11", 8'h08);
        tick(); check("rotate_12", 8'h10);

        // Hold for 11 edges.
        shift_enable = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("hold_%0d", i), 8'h10);
        end

        // Seven enabled edges wrap through 80 -> 01.
        shift_enable = 1'b1;
        tick(); check("resume_0", 8'h20);
        tick(); check("resume_1", 8'h40);
        tick(); check("resume_2", 8'h80);
        tick(); check("resume_3", 8'h01);
        tick(); check("resume_4", 8'h02);
        tick(); check("resume_5", 8'h04);
        tick(); check("resume_6", 8'h08);

        // Advance to 8'h40, then reset between edges.
        tick(); check("pre_rst_0", 8'h10);
        tick(); check("pre_rst_1", 8'h20);
        tick(); check("pre_rst_2", 8'h40);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_async", 8'h01);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check("post_rst_first", 8'h02);

`ifndef MASK_GEN_ASSERT_EN
        // Self-correction from zero and from multi-hot, with shift disabled.
        @(negedge clk);
        shift_enable = 1'b0;
        force dut.u_ring.mask_q = 8'h00;
        #1 release dut.u_ring.mask_q;
        tick();
        check("fix_zero", 8'h01);

        @(negedge clk);
        force dut.u_ring.mask_q = 8'h03;
        #1 release dut.u_ring.mask_q;
        tick();
        check("fix_multi", 8'h01);

        tick();
        check("fix_hold", 8'h01);

        shift_enable = 1'b1;
        tick();
        check("fix_then_rotate", 8'h02);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mask_gen.md
MASK_GEN -- requirements
Module: mask_gen

Interface
REQ-001 The block SHALL have parameter NB, default 8, giving the mask width in bits; legal range is NB >= 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port shift_enable, input, 1 bit: when 1, the mask advances one position per clock.
REQ-005 The block SHALL have port mask, output, NB bits: the one-hot rotating mask, driven directly from a register.

Function
REQ-006 mask SHALL always be one-hot, with exactly one bit set, in every cycle outside the self-correction case of REQ-010.
REQ-007 On a rising clk with shift_enable=1, mask SHALL rotate left by one: new mask = {mask[NB-2:0], mask[NB-1]}.
REQ-008 On a rising clk with shift_enable=0, mask SHALL hold its value, with no limit on the hold length.
REQ-009 Wrap-around: when bit NB-1 is set and shift_enable=1, the next mask SHALL be bit 0 only, so the period is NB enabled clocks.
REQ-010 Self-correction: if the register is ever not one-hot (zero or multi-hot), the next rising clk SHALL load bit 0 only, regardless of shift_enable.
REQ-011 Latency: mask SHALL reflect a shift on the same rising edge that samples shift_enable=1, with no extra pipeline stage.
REQ-012 For NB=1, mask SHALL be constant 1'b1 after reset, and a rotate SHALL leave it unchanged.
REQ-013 The block SHALL have no combinational path from shift_enable to mask.

Reset
REQ-014 While n_rst=0, mask SHALL be bit 0 only (8'h01 for NB=8), applied asynchronously without waiting for a clock edge.
REQ-015 On reset deassertion, the first rising clk with shift_enable=1 SHALL produce bit 1 (8'h02 for NB=8).
REQ-016 Reset asserted mid-rotation SHALL override shift_enable and immediately return mask to bit 0.

Configuration
REQ-017 Macro MASK_GEN_ASSERT_EN SHALL control the compiled-in checks.
- Defined: the block SHALL compile in concurrent assertions that, outside reset, mask is one-hot ($onehot).
- Defined: a rising clk with shift_enable=0 SHALL leave mask unchanged.
- Defined: a rising clk with shift_enable=1 SHALL give mask equal to the previous mask rotated left by one.
- Defined: any assertion failure SHALL report $error with the current and previous mask values.
- Not defined: no assertion code SHALL be elaborated, and the RTL behaviour SHALL be identical.

Structure
REQ-018 Package mask_gen_pkg SHALL hold the default-width constant MASK_GEN_NB_DEFAULT = 8.
REQ-019 mask_gen_pkg SHALL also hold a function rotl1(vec) returning the left rotation by one.
REQ-020 mask_gen_pkg SHALL also hold a function is_onehot(vec) returning the one-hot check.
REQ-021 A sub-module mask_gen_ring SHALL hold the NB-bit ring register, with async reset to bit 0, enable, and the self-correction of REQ-010.
REQ-022 The top level mask_gen SHALL instantiate mask_gen_ring and hold the optional assertions.
REQ-023 An NB value < 1 SHALL trigger an elaboration-time $fatal.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, all with NB=8:
- Hold n_rst=0 with shift_enable=1 -> mask=8'h01 with no clock edge needed.
- Release n_rst at a falling edge, then 8 rising edges with shift_enable=1 -> mask steps 02,04,08,10,20,40,80 and wraps back to 01.
- Continue to 12 rising edges in total -> mask=8'h10; then drop shift_enable for 11 edges -> mask stays 8'h10.
- Re-raise shift_enable for 7 edges -> mask=8'h08 (wrap through 80->01).
- Assert n_rst asynchronously while mask=8'h40, between clock edges -> mask=8'h01 immediately; after release, the next enabled edge -> 8'h02.
- Force the ring register to 8'h00, then 8'h03, and clock once with shift_enable=0 -> mask=8'h01; also run one pass with MASK_GEN_ASSERT_EN defined -> no assertion fires.
